// File: rtl/conv_pkg.sv
// Shared definitions for the 2-D convolution MAC: data width, FSM states
// and the signed saturation helper.
package conv_pkg;

   localparam int DATA_W   = 32;
   localparam int SAT_IN_W = 128;

   typedef enum logic [1:0] {StIdle, StMac, StOut, StDone} conv_state_e;

   // v is a sign-extended accumulator; clamp it to the signed 32-bit range.
   function automatic logic [DATA_W-1:0] sat32(input logic [SAT_IN_W-1:0] v);
      logic [DATA_W-1:0] r;
      if (!v[SAT_IN_W-1] && (|v[SAT_IN_W-2:DATA_W-1])) begin
         r = 32'h7FFF_FFFF;
      end else if (v[SAT_IN_W-1] && !(&v[SAT_IN_W-2:DATA_W-1])) begin
         r = 32'h8000_0000;
      end else begin
         r = v[DATA_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed 32x32 multiplier feeding a wide accumulator with clear and enable.
module conv_mac
   import conv_pkg::*;
#(
   parameter int ACC_W = 69
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [ACC_W-1:0]  acc_o
);

   logic signed [63:0] prod;
   logic [ACC_W-1:0]   acc_d, acc_q;

   assign prod = 64'($signed(a_i)) * 64'($signed(b_i));

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/conv2d_mac.sv
// Valid-region 2-D convolution: one MAC term per cycle, one saturated result
// per output pixel in raster order with a valid/ready handshake.
module conv2d_mac
   import conv_pkg::*;
#(
   parameter int KSIZE = 5,
   parameter int ISIZE = 8,
   localparam int OSIZE = ISIZE - KSIZE + 1,
   localparam int OW    = (OSIZE > 1) ? $clog2(OSIZE) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       kernel [0:KSIZE-1][0:KSIZE-1],
   input  logic [31:0]       image  [0:ISIZE-1][0:ISIZE-1],
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OW-1:0]     out_row,
   output logic [OW-1:0]     out_col,
   output logic              busy,
   output logic              done
);

   localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int IW    = (ISIZE > 1) ? $clog2(ISIZE) : 1;
   localparam int ACC_W = 64 + $clog2(KSIZE * KSIZE);
   localparam logic [KW-1:0] KLAST = KW'(KSIZE - 1);
   localparam logic [OW-1:0] OLAST = OW'(OSIZE - 1);

   conv_state_e state_q, state_d;
   logic [OW-1:0] orow_q, orow_d, ocol_q, ocol_d;
   logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          done_q, done_d;
   logic          mac_clr, mac_en;
   logic [IW-1:0] ir, ic;
   logic signed [ACC_W-1:0] acc;

   assign ir = IW'(orow_q) + IW'(kr_q);
   assign ic = IW'(ocol_q) + IW'(kc_q);

   conv_mac #(
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr_i (mac_clr),
      .en_i  (mac_en),
      .a_i   (image[ir][ic]),
      .b_i   (kernel[kr_q][kc_q]),
      .acc_o (acc)
   );

   always_comb begin
      state_d     = state_q;
      orow_d      = orow_q;
      ocol_d      = ocol_q;
      kr_d        = kr_q;
      kc_d        = kc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      mac_clr     = 1'b0;
      mac_en      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StMac;
               orow_d  = '0;
               ocol_d  = '0;
               kr_d    = '0;
               kc_d    = '0;
               mac_clr = 1'b1;
            end
         end
         StMac: begin
            mac_en = 1'b1;
            if (kc_q == KLAST) begin
               kc_d = '0;
               if (kr_q == KLAST) begin
                  kr_d    = '0;
                  state_d = StOut;
               end else begin
                  kr_d = kr_q + KW'(1);
               end
            end else begin
               kc_d = kc_q + KW'(1);
            end
         end
         StOut: begin
            // First OUT cycle registers the clamped sum; then wait for the handshake.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = sat32(SAT_IN_W'(acc));
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               mac_clr     = 1'b1;
               kr_d        = '0;
               kc_d        = '0;
               state_d     = StMac;
               if (ocol_q == OLAST) begin
                  ocol_d = '0;
                  if (orow_q == OLAST) begin
                     orow_d  = '0;
                     state_d = StDone;
                     done_d  = 1'b1;
                  end else begin
                     orow_d = orow_q + OW'(1);
                  end
               end else begin
                  ocol_d = ocol_q + OW'(1);
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         orow_q      <= '0;
         ocol_q      <= '0;
         kr_q        <= '0;
         kc_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         orow_q      <= orow_d;
         ocol_q      <= ocol_d;
         kr_q        <= kr_d;
         kc_q        <= kc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_row   = orow_q;
   assign out_col   = ocol_q;
   assign done      = done_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv2d_mac.sv
// Directed bench for conv2d_mac: a 3x3-on-4x4 instance for most scenarios and
// a 3x3-on-5x5 instance for the kernel-position checks.
module tb_conv2d_mac;

   logic clk = 1'b0;
   logic reset;

   logic        start_a, ready_a, valid_a, busy_a, done_a;
   logic [31:0] data_a;
   logic [0:0]  row_a, col_a;
   logic [31:0] ker_a [0:2][0:2];
   logic [31:0] img_a [0:3][0:3];

   logic        start_b, ready_b, valid_b, busy_b, done_b;
   logic [31:0] data_b;
   logic [1:0]  row_b, col_b;
   logic [31:0] ker_b [0:2][0:2];
   logic [31:0] img_b [0:4][0:4];

   int tests = 0;
   int fails = 0;

   int          n_out, done_cnt, hold_err, busy_err;
   int          lat   [8];
   logic [31:0] got_d [8];
   int          got_r [8];
   int          got_c [8];

   always #5 clk = ~clk;

   conv2d_mac #(.KSIZE(3), .ISIZE(4)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .start     (start_a),
      .kernel    (ker_a),
      .image     (img_a),
      .out_data  (data_a),
      .out_valid (valid_a),
      .out_ready (ready_a),
      .out_row   (row_a),
      .out_col   (col_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   conv2d_mac #(.KSIZE(3), .ISIZE(5)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .start     (start_b),
      .kernel    (ker_b),
      .image     (img_b),
      .out_data  (data_b),
      .out_valid (valid_b),
      .out_ready (ready_b),
      .out_row   (row_b),
      .out_col   (col_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic [31:0] kval, input bit ramp, input logic [31:0] ival);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) ker_a[r][c] = kval;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) img_a[r][c] = ramp ? 32'(r * 4 + c) : ival;
   endtask

   // Drives one full run on instance A and records every accepted output.
   task automatic run_a(input int stall_idx, input bit poke);
      int cyc, entry, stall, since_done;
      bit prev_v;
      logic [31:0] held;
      n_out = 0; done_cnt = 0; hold_err = 0; busy_err = 0;
      for (int i = 0; i < 8; i++) begin
         lat[i] = -1; got_d[i] = 'x; got_r[i] = -1; got_c[i] = -1;
      end
      since_done = -1; prev_v = 1'b0; entry = 0; stall = 0; held = '0;
      start_a = 1'b1; ready_a = 1'b1;
      step();
      start_a = poke;
      cyc = 0;
      while (cyc < 300 && since_done < 3) begin
         if (since_done >= 1) begin
            start_a = 1'b0;
            if (busy_a !== 1'b0) busy_err++;
         end
         if (valid_a && !prev_v) begin
            if (n_out < 8) lat[n_out] = cyc - entry;
            stall = (n_out == stall_idx) ? 10 : 0;
            held = data_a;
         end
         if (valid_a) begin
            if (data_a !== held) hold_err++;
            if (stall > 0) begin
               ready_a = 1'b0;
               stall--;
            end else begin
               ready_a = 1'b1;
               if (n_out < 8) begin
                  got_d[n_out] = data_a;
                  got_r[n_out] = int'(row_a);
                  got_c[n_out] = int'(col_a);
               end
               n_out++;
               entry = cyc + 1;
            end
         end else begin
            ready_a = 1'b1;
         end
         if (done_a) begin
            done_cnt++;
            if (since_done < 0) since_done = 0;
         end
         prev_v = valid_a;
         step();
         cyc++;
         if (since_done >= 0) since_done++;
      end
      start_a = 1'b0;
   endtask

   task automatic check_a(input string name, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] exp_d [4];
      exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
      tests++;
      if (n_out !== 4) begin
         fails++; $display("FAIL %s_count got %0d want 4", name, n_out);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (got_d[i] !== exp_d[i]) begin
            fails++; $display("FAIL %s_data[%0d] got %h want %h", name, i, got_d[i], exp_d[i]);
         end
         tests++;
         if (got_r[i] !== i / 2 || got_c[i] !== i % 2) begin
            fails++;
            $display("FAIL %s_pos[%0d] got (%0d,%0d) want (%0d,%0d)", name, i, got_r[i],
                     got_c[i], i / 2, i % 2);
         end
      end
      tests++;
      if (done_cnt !== 1) begin
         fails++; $display("FAIL %s_done got %0d pulses want 1", name, done_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_a = 1'b1; start_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
      set_a(32'd1, 1'b0, 32'd1);
      step(); step();
      tests++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         fails++; $display("FAIL reset_flags got v=%b b=%b d=%b want 0", valid_a, busy_a, done_a);
      end
      tests++;
      if (data_a !== 32'h0 || row_a !== 1'b0 || col_a !== 1'b0) begin
         fails++; $display("FAIL reset_outs got %h (%0d,%0d) want 0", data_a, row_a, col_a);
      end
      tests++;
      if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
         fails++; $display("FAIL reset_b got b=%b v=%b want 0", busy_b, valid_b);
      end
      reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
      step();
      tests++;
      if (busy_a !== 1'b0) begin
         fails++; $display("FAIL reset_idle got busy=%b want 0", busy_a);
      end
   endtask

   task automatic test_ones();
      set_a(32'd1, 1'b0, 32'd1);
      run_a(-1, 1'b0);
      check_a("ones", 32'd9, 32'd9, 32'd9, 32'd9);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (lat[i] !== 10) begin
            fails++; $display("FAIL ones_latency[%0d] got %0d want 10", i, lat[i]);
         end
      end
   endtask

   task automatic test_signed();
      set_a(32'hFFFF_FFFF, 1'b1, 32'd0);
      run_a(-1, 1'b0);
      check_a("signed", 32'hFFFF_FFD3, 32'hFFFF_FFCA, 32'hFFFF_FFAF, 32'hFFFF_FFA6);
   endtask

   task automatic test_saturate();
      set_a(32'd2, 1'b0, 32'h7FFF_FFFF);
      run_a(-1, 1'b0);
      check_a("sat_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      set_a(32'hFFFF_FFFE, 1'b0, 32'h7FFF_FFFF);
      run_a(-1, 1'b0);
      check_a("sat_neg", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
   endtask

   task automatic test_backpressure();
      set_a(32'd1, 1'b1, 32'd0);
      run_a(1, 1'b0);
      check_a("stall", 32'd45, 32'd54, 32'd81, 32'd90);
      tests++;
      if (hold_err !== 0) begin
         fails++; $display("FAIL stall_hold got %0d changes want 0", hold_err);
      end
   endtask

   task automatic test_reset_mid();
      set_a(32'd1, 1'b1, 32'd0);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
         fails++; $display("FAIL midreset got v=%b b=%b want 0", valid_a, busy_a);
      end
      repeat (12) step();
      tests++;
      if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
         fails++; $display("FAIL midreset_quiet got v=%b b=%b want 0", valid_a, busy_a);
      end
      run_a(-1, 1'b0);
      check_a("after_reset", 32'd45, 32'd54, 32'd81, 32'd90);
   endtask

   task automatic test_start_ignored();
      set_a(32'd1, 1'b1, 32'd0);
      run_a(-1, 1'b1);
      check_a("start_busy", 32'd45, 32'd54, 32'd81, 32'd90);
      tests++;
      if (busy_err !== 0) begin
         fails++; $display("FAIL start_busy_restart got %0d busy cycles want 0", busy_err);
      end
   endtask

   // Single non-zero kernel tap at (kr0,kc0) selects image[orow+kr0][ocol+kc0].
   task automatic test_identity(input int kr0, input int kc0);
      int cnt, dn;
      logic [31:0] exp_v;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) ker_b[r][c] = (r == kr0 && c == kc0) ? 32'd1 : 32'd0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) img_b[r][c] = 32'(10 * r + c);
      cnt = 0; dn = 0;
      start_b = 1'b1; ready_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int cyc = 0; cyc < 130; cyc++) begin
         if (valid_b) begin
            exp_v = 32'(10 * (cnt / 3 + kr0) + (cnt % 3 + kc0));
            tests++;
            if (data_b !== exp_v) begin
               fails++; $display("FAIL ident_%0d%0d_data[%0d] got %0d want %0d", kr0, kc0, cnt,
                                 data_b, exp_v);
            end
            tests++;
            if (int'(row_b) !== cnt / 3 || int'(col_b) !== cnt % 3) begin
               fails++; $display("FAIL ident_%0d%0d_pos[%0d] got (%0d,%0d) want (%0d,%0d)", kr0,
                                 kc0, cnt, row_b, col_b, cnt / 3, cnt % 3);
            end
            cnt++;
         end
         if (done_b) dn++;
         step();
      end
      tests++;
      if (cnt !== 9 || dn !== 1) begin
         fails++; $display("FAIL ident_%0d%0d_count got %0d outs %0d done want 9 and 1", kr0, kc0,
                           cnt, dn);
      end
   endtask

   initial begin
      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) ker_b[r][c] = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) img_b[r][c] = '0;
      test_reset();
      test_ones();
      test_signed();
      test_saturate();
      test_backpressure();
      test_reset_mid();
      test_start_ignored();
      test_identity(1, 1);
      test_identity(0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
